// File: rtl/boa_mem_arbiter_pkg.sv
// Shared types and constants for the Boa32 two-master memory arbiter.
package boa_arb_pkg;

    localparam int BOA_ARB_NMASTERS = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } boa_arb_state_t;

endpackage

// File: rtl/boa_mem_arbiter_if.sv
// One Boa32 memory-bus port: request side driven by a master, completion side by a slave.
interface boa_mem_arbiter_if #(
    parameter int alen = 32,
    parameter int dlen = 32
);
    logic              re;
    logic [dlen/8-1:0] we;
    logic [alen-1:0]   addr;
    logic [dlen-1:0]   wdata;
    logic              ready;
    logic [dlen-1:0]   rdata;

    modport master (output re, we, addr, wdata, input ready, rdata);
    modport slave  (input re, we, addr, wdata, output ready, rdata);
endinterface

// File: rtl/boa_mem_arbiter_pick.sv
// Tie-break for the arbiter. BOA_ARB_ROUND_ROBIN_EN selects round-robin,
// otherwise m0 (data bus) has fixed priority.
module boa_arb_pick
    import boa_arb_pkg::*;
(
    input  logic [BOA_ARB_NMASTERS-1:0] req,
    input  logic                        last,
    output logic [BOA_ARB_NMASTERS-1:0] gnt
);

    logic [BOA_ARB_NMASTERS-1:0] tie_gnt;

`ifdef BOA_ARB_ROUND_ROBIN_EN
    // The master that was not granted last gets the tie.
    assign tie_gnt = last ? 2'b01 : 2'b10;
`else
    logic unused_last;
    assign unused_last = last;
    assign tie_gnt     = 2'b01;
`endif

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = tie_gnt;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/boa_mem_arbiter.sv
// Two-master, one-slave Boa32 memory arbiter. Grant is registered and held until
// s.ready; buses are steered combinationally from it. Tie policy: BOA_ARB_ROUND_ROBIN_EN.
module boa_mem_arbiter
    import boa_arb_pkg::*;
#(
    parameter int alen = 32,
    parameter int dlen = 32
) (
    input logic                clk,
    input logic                rst_n,
    boa_mem_arbiter_if.slave   m0,
    boa_mem_arbiter_if.slave   m1,
    boa_mem_arbiter_if.master  s
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_GRANT0 = GRANT0;
    localparam logic [1:0] ST_GRANT1 = GRANT1;

    logic [1:0]                  state;
    logic                        last;
    logic [BOA_ARB_NMASTERS-1:0] req;
    logic [BOA_ARB_NMASTERS-1:0] gnt;

    assign req[0] = m0.re | (|m0.we);
    assign req[1] = m1.re | (|m1.we);

    boa_arb_pick u_pick (
        .req  (req),
        .last (last),
        .gnt  (gnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            last  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt[0]) begin
                        state <= ST_GRANT0;
                        last  <= 1'b0;
                    end else if (gnt[1]) begin
                        state <= ST_GRANT1;
                        last  <= 1'b1;
                    end
                end
                ST_GRANT0, ST_GRANT1: begin
                    // Grant is held even if the owner drops its request early.
                    if (s.ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        s.re      = 1'b0;
        s.we      = '0;
        s.addr    = '0;
        s.wdata   = '0;
        m0.ready  = 1'b0;
        m0.rdata  = '0;
        m1.ready  = 1'b0;
        m1.rdata  = '0;
        case (state)
            ST_GRANT0: begin
                s.re     = m0.re;
                s.we     = m0.we;
                s.addr   = m0.addr;
                s.wdata  = m0.wdata;
                m0.ready = s.ready;
                m0.rdata = s.rdata;
            end
            ST_GRANT1: begin
                s.re     = m1.re;
                s.we     = m1.we;
                s.addr   = m1.addr;
                s.wdata  = m1.wdata;
                m1.ready = s.ready;
                m1.rdata = s.rdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_boa_mem_arbiter.sv
// Directed, scoreboard-based bench for boa_mem_arbiter (both tie policies).
module tb_boa_mem_arbiter;

    logic clk;
    logic rst_n;

    boa_mem_arbiter_if #(.alen(32), .dlen(32)) m0_bus ();
    boa_mem_arbiter_if #(.alen(32), .dlen(32)) m1_bus ();
    boa_mem_arbiter_if #(.alen(32), .dlen(32)) s_bus ();

    boa_mem_arbiter #(.alen(32), .dlen(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .m0    (m0_bus),
        .m1    (m1_bus),
        .s     (s_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned mst;
        logic [31:0] addr;
        logic [31:0] rdata;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on a cycle where a master should see ready; pops the oldest expectation.
    task automatic sb_check(input string tag);
        exp_t        e;
        int unsigned mst;
        logic [31:0] rd;
        mst = m0_bus.ready ? 0 : (m1_bus.ready ? 1 : 2);
        rd  = (mst == 1) ? m1_bus.rdata : m0_bus.rdata;
        if (sbq.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sbq.pop_front();
            check({tag, "_mst"},   64'(mst),        64'(e.mst));
            check({tag, "_addr"},  64'(s_bus.addr), 64'(e.addr));
            check({tag, "_rdata"}, 64'(rd),         64'(e.rdata));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit found;
        rst_n        = 1'b0;
        m0_bus.re    = 1'b0; m0_bus.we = '0; m0_bus.addr = '0; m0_bus.wdata = '0;
        m1_bus.re    = 1'b0; m1_bus.we = '0; m1_bus.addr = '0; m1_bus.wdata = '0;
        s_bus.ready  = 1'b0; s_bus.rdata = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_re",     64'(s_bus.re),    64'd0);
        check("rst_s_addr",   64'(s_bus.addr),  64'd0);
        check("rst_m0_ready", 64'(m0_bus.ready), 64'd0);
        check("rst_m1_ready", 64'(m1_bus.ready), 64'd0);
        tick();
        rst_n = 1'b1;

        // Single zero-wait read from m0
        m0_bus.re = 1'b1; m0_bus.addr = 32'h100;
        sbq.push_back('{mst: 0, addr: 32'h100, rdata: 32'hDEADBEEF});
        @(negedge clk);
        check("rd_idle_s_re",  64'(s_bus.re),     64'd0);
        check("rd_idle_ready", 64'(m0_bus.ready), 64'd0);
        tick();
        s_bus.ready = 1'b1; s_bus.rdata = 32'hDEADBEEF;
        @(negedge clk);
        check("rd_m0_ready", 64'(m0_bus.ready), 64'd1);
        check("rd_m1_rdata", 64'(m1_bus.rdata), 64'd0);
        sb_check("rd");
        tick();
        m0_bus.re = 1'b0; m0_bus.addr = '0; s_bus.ready = 1'b0; s_bus.rdata = '0;

        // Wait-state write from m1, ready in 3rd granted cycle
        m1_bus.we = 4'b0011; m1_bus.addr = 32'h20; m1_bus.wdata = 32'h1234;
        sbq.push_back('{mst: 1, addr: 32'h20, rdata: 32'h0});
        @(negedge clk);
        check("wr_idle_s_we", 64'(s_bus.we), 64'd0);
        for (int j = 1; j <= 3; j++) begin
            tick();
            s_bus.ready = (j == 3);
            @(negedge clk);
            check($sformatf("wr_s_we_%0d", j),    64'(s_bus.we),     64'h3);
            check($sformatf("wr_s_addr_%0d", j),  64'(s_bus.addr),   64'h20);
            check($sformatf("wr_s_wdata_%0d", j), 64'(s_bus.wdata),  64'h1234);
            check($sformatf("wr_m1_ready_%0d", j), 64'(m1_bus.ready), 64'(j == 3));
            check($sformatf("wr_m0_ready_%0d", j), 64'(m0_bus.ready), 64'd0);
            if (j == 3) sb_check("wr");
        end
        tick();
        m1_bus.we = '0; m1_bus.addr = '0; m1_bus.wdata = '0; s_bus.ready = 1'b0;

        // m1 arrives while m0 is mid-access
        m0_bus.re = 1'b1; m0_bus.addr = 32'h300;
        sbq.push_back('{mst: 0, addr: 32'h300, rdata: 32'h1111});
        sbq.push_back('{mst: 1, addr: 32'h500, rdata: 32'h2222});
        @(negedge clk);
        tick();
        m1_bus.re = 1'b1; m1_bus.addr = 32'h500;
        @(negedge clk);
        check("mid_s_addr_a",   64'(s_bus.addr),   64'h300);
        check("mid_m1_ready_a", 64'(m1_bus.ready), 64'd0);
        tick();
        @(negedge clk);
        check("mid_s_addr_b",   64'(s_bus.addr),   64'h300);
        check("mid_m1_ready_b", 64'(m1_bus.ready), 64'd0);
        tick();
        s_bus.ready = 1'b1; s_bus.rdata = 32'h1111;
        @(negedge clk);
        sb_check("mid_m0");
        tick();
        m0_bus.re = 1'b0; m0_bus.addr = '0; s_bus.ready = 1'b0; s_bus.rdata = '0;
        @(negedge clk);
        check("mid_idle_s_addr",   64'(s_bus.addr),   64'd0);
        check("mid_idle_m1_ready", 64'(m1_bus.ready), 64'd0);
        tick();
        s_bus.ready = 1'b1; s_bus.rdata = 32'h2222;
        @(negedge clk);
        sb_check("mid_m1");
        tick();
        m1_bus.re = 1'b0; m1_bus.addr = '0; s_bus.ready = 1'b0; s_bus.rdata = '0;

        // Asynchronous reset in the middle of a GRANT1 access
        m1_bus.re = 1'b1; m1_bus.addr = 32'h600;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("rstg_granted_addr", 64'(s_bus.addr), 64'h600);
        #2;
        rst_n = 1'b0;
        #1;
        check("rstg_s_re",     64'(s_bus.re),     64'd0);
        check("rstg_s_addr",   64'(s_bus.addr),   64'd0);
        check("rstg_m1_ready", 64'(m1_bus.ready), 64'd0);
        m1_bus.re = 1'b0; m1_bus.addr = '0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rstg_idle_s_addr", 64'(s_bus.addr), 64'd0);
        check("rstg_idle_s_re",   64'(s_bus.re),   64'd0);

        // Continuous tie with a zero-wait slave, starting from reset (last = 1)
        tick();
        m0_bus.re = 1'b1; m0_bus.addr = 32'h40;
        m1_bus.re = 1'b1; m1_bus.addr = 32'h80;
        s_bus.ready = 1'b1; s_bus.rdata = 32'hCAFE0001;
        for (int g = 0; g < 4; g++) begin
`ifdef BOA_ARB_ROUND_ROBIN_EN
            if (g % 2 == 0) sbq.push_back('{mst: 0, addr: 32'h40, rdata: 32'hCAFE0001});
            else            sbq.push_back('{mst: 1, addr: 32'h80, rdata: 32'hCAFE0001});
`else
            sbq.push_back('{mst: 0, addr: 32'h40, rdata: 32'hCAFE0001});
`endif
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i % 2 == 1) begin
                sb_check($sformatf("tie_g%0d", i / 2));
            end else begin
                check($sformatf("tie_idle_ready_%0d", i),
                      64'({m1_bus.ready, m0_bus.ready}), 64'd0);
            end
        end
        tick();
        m0_bus.re = 1'b0; m0_bus.addr = '0;
        sbq.push_back('{mst: 1, addr: 32'h80, rdata: 32'hCAFE0001});
        found = 1'b0;
        for (int k = 0; k < 2 && !found; k++) begin
            @(negedge clk);
            if (m1_bus.ready) begin
                sb_check("tie_m1_after_drop");
                found = 1'b1;
            end
        end
        check("tie_m1_within_2", 64'(found), 64'd1);
        tick();
        m1_bus.re = 1'b0; m1_bus.addr = '0; s_bus.ready = 1'b0; s_bus.rdata = '0;

        check("sb_drained", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
